// File: rtl/seven_seg_scan_controller.sv
// Double-buffered 7-segment scan scheduler with blank gaps and frame_sync.
// Optional SEVEN_SEG_SCAN_BRIGHTNESS_EN adds a 4-bit PWM brightness input.
module seven_seg_scan_controller #(
  parameter int w_digit      = 4,
  parameter int dwell_cycles = 12500,
  parameter int blank_cycles = 250
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   frame_valid,
  output logic                   frame_ready,
  input  logic [8*w_digit-1:0]   frame_segs,
`ifdef SEVEN_SEG_SCAN_BRIGHTNESS_EN
  input  logic [3:0]             brightness,
`endif
  output logic [7:0]             abcdefgh,
  output logic [w_digit-1:0]     digit,
  output logic                   frame_sync
);

  localparam int cnt_max =
    (dwell_cycles > blank_cycles) ? dwell_cycles : blank_cycles;
  localparam int cw = (cnt_max > 1) ? $clog2(cnt_max) : 1;
  localparam int iw = (w_digit > 1) ? $clog2(w_digit) : 1;

  localparam logic [cw-1:0] dwell_last = cw'(dwell_cycles - 1);
  localparam logic [cw-1:0] blank_last = cw'(blank_cycles - 1);
  localparam logic [iw-1:0] idx_last   = iw'(w_digit - 1);

  typedef enum logic {
    BLANK,
    ON
  } state_t;

  state_t               state, state_n;
  logic [iw-1:0]        idx, idx_n;
  logic [cw-1:0]        cnt, cnt_n;
  logic                 wrap;
  logic [8*w_digit-1:0] active, shadow, active_n;
  logic                 pending, pending_n;
  logic                 accept, xfer;
  logic [7:0]           seg_sel;
  logic                 lit;

  assign accept = frame_valid && frame_ready;
  // Frame swaps only at the start of digit 0, so a scan never tears.
  assign xfer   = (state == BLANK) && (idx == '0) && pending;

  always_comb begin
    pending_n = pending;
    if (accept)
      pending_n = 1'b1;
    else if (xfer)
      pending_n = 1'b0;
  end

  assign active_n = xfer ? shadow : active;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    wrap    = 1'b0;
    if (!enable) begin
      state_n = BLANK;
      idx_n   = '0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        BLANK: begin
          if (cnt == blank_last) begin
            state_n = ON;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ON: begin
          if (cnt == dwell_last) begin
            state_n = BLANK;
            cnt_n   = '0;
            wrap    = (idx == idx_last);
            idx_n   = wrap ? '0 : idx + 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign seg_sel = active_n[8*idx_n +: 8];

`ifdef SEVEN_SEG_SCAN_BRIGHTNESS_EN
  logic [3:0] cnt_lo;
  assign cnt_lo = 4'(cnt_n);
  assign lit    = (cnt_lo <= brightness);
`else
  assign lit    = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BLANK;
      idx         <= '0;
      cnt         <= '0;
      active      <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      frame_ready <= 1'b1;
      abcdefgh    <= '0;
      digit       <= '0;
      frame_sync  <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      active      <= active_n;
      if (accept)
        shadow <= frame_segs;
      pending     <= pending_n;
      frame_ready <= !pending_n;
      frame_sync  <= wrap;
      if (state_n == ON) begin
        digit    <= w_digit'(1) << idx_n;
        abcdefgh <= lit ? seg_sel : 8'h00;
      end else begin
        digit    <= '0;
        abcdefgh <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Bench for seven_seg_scan_controller: per-cycle scoreboard from a
// scan-phase model, a stimulus table, and directed corner sequences.
module tb_seven_seg_scan_controller;

  localparam int W = 4;
  localparam int B = 2;
`ifdef SEVEN_SEG_SCAN_BRIGHTNESS_EN
  localparam int D = 16;
`else
  localparam int D = 4;
`endif
  localparam int S = B + D;
  localparam int P = W * S;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        frame_valid = 1'b0;
  logic        frame_ready;
  logic [31:0] frame_segs = '0;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;
  logic        frame_sync;
`ifdef SEVEN_SEG_SCAN_BRIGHTNESS_EN
  logic [3:0]  brightness = 4'd15;
`endif

  seven_seg_scan_controller #(
    .w_digit(W),
    .dwell_cycles(D),
    .blank_cycles(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .frame_segs(frame_segs),
`ifdef SEVEN_SEG_SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .abcdefgh(abcdefgh),
    .digit(digit),
    .frame_sync(frame_sync)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] dig;
    logic [7:0] seg;
    logic       fs;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];

  // Reference: position mt within a scan period instead of an FSM.
  int          mt = 0;
  logic [31:0] mact = '0;
  logic [31:0] mshd = '0;
  logic        mpend = 1'b0;
  logic        mfs = 1'b0;
  logic        mlive = 1'b0;

  function automatic exp_t model_out();
    exp_t e;
    int d;
    int o;
    d = mt / S;
    o = mt % S;
    e.fs  = mfs;
    e.rdy = !mpend;
    e.dig = '0;
    e.seg = '0;
    if (o >= B) begin
      e.dig = 4'(1 << d);
      e.seg = mact[8*d +: 8];
`ifdef SEVEN_SEG_SCAN_BRIGHTNESS_EN
      if (((o - B) % 16) > int'(brightness))
        e.seg = 8'h00;
`endif
    end
    return e;
  endfunction

  always @(posedge clk) begin
    logic acc;
    if (rst) begin
      mlive = 1'b1;
      mt    = 0;
      mact  = '0;
      mshd  = '0;
      mpend = 1'b0;
      mfs   = 1'b0;
    end else if (mlive) begin
      acc = frame_valid && !mpend;
      if (mpend && mt < B) begin
        mact  = mshd;
        mpend = 1'b0;
      end
      if (acc) begin
        mshd  = frame_segs;
        mpend = 1'b1;
      end
      if (!enable) begin
        mt  = 0;
        mfs = 1'b0;
      end else begin
        mt  = (mt + 1) % P;
        mfs = (mt == 0);
      end
    end
    if (mlive)
      exp_q.push_back(model_out());
  end

  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {digit, abcdefgh, frame_sync, frame_ready};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scoreboard @%0t got dig=%b seg=%h fs=%b rdy=%b want dig=%b seg=%h fs=%b rdy=%b",
                 $time, a.dig, a.seg, a.fs, a.rdy, e.dig, e.seg, e.fs, e.rdy);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic v,
                      input logic [31:0] f);
    rst         = r;
    enable      = e;
    frame_valid = v;
    frame_segs  = f;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic        v;
    logic [31:0] f;
    int          n;
    logic [3:0]  dig;
    logic [7:0]  seg;
    logic        fs;
    logic        rdy;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int  waited;
    logic seen;

`ifdef SEVEN_SEG_SCAN_BRIGHTNESS_EN
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, '0);
    brightness = 4'd3;
    step(1'b0, 1'b1, 1'b1, 32'h11223344);
    step(1'b0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 16; k++) begin
      chk("br3_digit", 32'(digit), 32'h1);
      chk("br3_seg", 32'(abcdefgh), (k <= 3) ? 32'h44 : 32'h00);
      step(1'b0, 1'b1, 1'b0, '0);
    end
    brightness = 4'd15;
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    for (int k = 0; k < 16; k++) begin
      chk("br15_digit", 32'(digit), 32'h2);
      chk("br15_seg", 32'(abcdefgh), 32'h33);
      step(1'b0, 1'b1, 1'b0, '0);
    end
`else
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h0,        2,  4'h0, 8'h00, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h11223344, 1,  4'h0, 8'h00, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0,        1,  4'h1, 8'h44, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0,        8,  4'h2, 8'h33, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h0,        14, 4'h0, 8'h00, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 32'h0,        13, 4'h0, 8'h00, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'hAAAAAAAA, 1,  4'h4, 8'h22, 1'b0, 1'b0};

    for (int i = 0; i < 7; i++) begin
      repeat (tbl[i].n) step(tbl[i].rst, tbl[i].en, tbl[i].v, tbl[i].f);
      chk("tbl_digit", 32'(digit), 32'(tbl[i].dig));
      chk("tbl_seg", 32'(abcdefgh), 32'(tbl[i].seg));
      chk("tbl_sync", 32'(frame_sync), 32'(tbl[i].fs));
      chk("tbl_ready", 32'(frame_ready), 32'(tbl[i].rdy));
    end

    // Back-pressure: 0x55.. held until the AA frame moves to active.
    waited = 0;
    seen   = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      step(1'b0, 1'b1, 1'b1, 32'h55555555);
      waited++;
      if (frame_ready) seen = 1'b1;
    end
    if (!seen) $display("FAIL bp_timeout: frame_ready never returned");
    chk("bp_ready_back", 32'(seen), 32'h1);
    chk("bp_wait_len", 32'(waited), 32'd11);
    step(1'b0, 1'b1, 1'b1, 32'h55555555);
    chk("bp_accepted", 32'(frame_ready), 32'h0);
    chk("bp_old_digit", 32'(digit), 32'h1);
    chk("bp_old_seg", 32'(abcdefgh), 32'hAA);
    repeat (24) step(1'b0, 1'b1, 1'b0, '0);
    chk("bp_new_seg", 32'(abcdefgh), 32'h55);

    // No tearing.
    step(1'b0, 1'b1, 1'b1, 32'h01020304);
    repeat (23) step(1'b0, 1'b1, 1'b0, '0);
    chk("nt_d0", 32'(abcdefgh), 32'h04);
    repeat (12) step(1'b0, 1'b1, 1'b0, '0);
    chk("nt_d2_digit", 32'(digit), 32'h4);
    step(1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
    chk("nt_d2_seg", 32'(abcdefgh), 32'h02);
    repeat (5) step(1'b0, 1'b1, 1'b0, '0);
    chk("nt_d3_digit", 32'(digit), 32'h8);
    chk("nt_d3_seg", 32'(abcdefgh), 32'h01);
    repeat (6) step(1'b0, 1'b1, 1'b0, '0);
    chk("nt_next_seg", 32'(abcdefgh), 32'hFF);
    repeat (6) step(1'b0, 1'b1, 1'b0, '0);
    chk("nt_d1_digit", 32'(digit), 32'h2);

    // Enable drop during digit 1.
    step(1'b0, 1'b0, 1'b0, '0);
    chk("en_off_digit", 32'(digit), 32'h0);
    chk("en_off_seg", 32'(abcdefgh), 32'h0);
    chk("en_off_sync", 32'(frame_sync), 32'h0);
    repeat (9) step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("en_on_blank", 32'(digit), 32'h0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("en_on_digit", 32'(digit), 32'h1);
    chk("en_on_seg", 32'(abcdefgh), 32'hFF);

    // Reset with a pending frame.
    repeat (12) step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b1, 32'h12345678);
    chk("rs_pending", 32'(frame_ready), 32'h0);
    step(1'b1, 1'b1, 1'b0, '0);
    chk("rs_digit", 32'(digit), 32'h0);
    chk("rs_seg", 32'(abcdefgh), 32'h0);
    chk("rs_ready", 32'(frame_ready), 32'h1);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("rs_d0_digit", 32'(digit), 32'h1);
    chk("rs_d0_seg", 32'(abcdefgh), 32'h00);
    repeat (24) step(1'b0, 1'b1, 1'b0, '0);
    chk("rs_d0_seg_next", 32'(abcdefgh), 32'h00);
`endif

    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
